// File: rtl/agent_seq_pkg.sv
// agent_seq_pkg: shared definitions for the sequential Q-learning agent.
//   - action-field width helpers (road bits RW, duration bits DW)
//   - FSM state encoding
//   - LFSR feedback mask
//   - saturation helper for the Bellman write-back
package agent_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_ACT    = 3'd3;
  localparam logic [2:0] S_WAIT_R = 3'd4;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int rw_of(input int n_road);
    return (n_road <= 2) ? 1 : $clog2(n_road);
  endfunction

  function automatic int dw_of(input int l_width);
    return l_width / 2;
  endfunction

  // Clamp a sign-extended value into the signed range of a qw-bit field.
  function automatic logic signed [31:0] sat_q(input logic signed [31:0] v, input int qw);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (qw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/agent_seq_q_update.sv
// agent_seq_q_update: Bellman write-back datapath.
//   td    = R_prev + (Q_max >>> gamma) - Q_act_prev   (Q_WIDTH+2 bits)
//   Q_new = sat(Q_act_prev + (td >>> alpha))
// Ports: clk/rst, en (one-cycle update request), r_prev, q_max, q_act_prev,
//        alpha/gamma shift amounts, addr_in (previous action);
//        registered upd_valid strobe, upd_addr, q_new.
module agent_seq_q_update
  import agent_seq_pkg::*;
#(
  parameter int Q_WIDTH = 16,
  parameter int R_WIDTH = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [R_WIDTH-1:0] r_prev,
  input  logic [Q_WIDTH-1:0] q_max,
  input  logic [Q_WIDTH-1:0] q_act_prev,
  input  logic [2:0]         alpha,
  input  logic [2:0]         gamma,
  input  logic [AW-1:0]      addr_in,
  output logic               upd_valid,
  output logic [AW-1:0]      upd_addr,
  output logic [Q_WIDTH-1:0] q_new
);

  localparam int TW = Q_WIDTH + 2;

  logic signed [TW-1:0] r_ext, qmax_sh, qact_ext, td, td_sh;
  logic signed [TW:0]   sum;
  logic signed [31:0]   sat_v;

  logic               upd_valid_q, upd_valid_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [Q_WIDTH-1:0] qnew_q, qnew_d;

  always_comb begin
    r_ext    = TW'($signed(r_prev));
    qmax_sh  = TW'($signed(q_max) >>> gamma);
    qact_ext = TW'($signed(q_act_prev));
    td       = r_ext + qmax_sh - qact_ext;
    td_sh    = td >>> alpha;
    // One extra bit so the add cannot wrap before saturation.
    sum      = (TW+1)'(qact_ext) + (TW+1)'(td_sh);
    sat_v    = sat_q(32'(sum), Q_WIDTH);

    upd_valid_d = en;
    addr_d      = addr_q;
    qnew_d      = qnew_q;
    if (en) begin
      addr_d = addr_in;
      qnew_d = sat_v[Q_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      addr_q      <= '0;
      qnew_q      <= '0;
    end else begin
      upd_valid_q <= upd_valid_d;
      addr_q      <= addr_d;
      qnew_q      <= qnew_d;
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_addr  = addr_q;
  assign q_new     = qnew_q;

endmodule

// File: rtl/agent_seq.sv
// agent_seq: sequential epsilon-greedy Q-learning agent.
// Per step: accept a Q-row for road_sel (q_valid/q_ready), scan it one level
// per cycle for max/argmax, pick a duration (greedy or LFSR exploration),
// present action A={dur,road} (act_valid/act_ready), then wait for the reward
// (r_valid/R). The Bellman write-back for the previous action is issued from
// the DECIDE cycle and appears as a one-cycle upd_valid with upd_addr/Q_new.
// Ports: clk, rst (sync, active high), mode, epsilon, alpha, gamma, road_en,
//        road_sel, q_valid/q_ready/q_row, act_valid/act_ready/A,
//        r_valid/R, upd_valid/upd_addr/Q_new.
module agent_seq
  import agent_seq_pkg::*;
#(
  parameter int         N_ROAD  = 4,
  parameter int         L_WIDTH = 4,
  parameter int         Q_WIDTH = 16,
  parameter int         R_WIDTH = 16,
  parameter logic [7:0] SEED    = 8'hA5,
  localparam int        RW      = rw_of(N_ROAD),
  localparam int        DW      = dw_of(L_WIDTH),
  localparam int        N_LEVEL = 2 ** DW,
  localparam int        AW      = RW + DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [7:0]                 epsilon,
  input  logic [2:0]                 alpha,
  input  logic [2:0]                 gamma,
  input  logic [N_ROAD-1:0]          road_en,
  output logic [RW-1:0]              road_sel,
  input  logic                       q_valid,
  output logic                       q_ready,
  input  logic [Q_WIDTH*N_LEVEL-1:0] q_row,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [AW-1:0]              A,
  input  logic                       r_valid,
  input  logic [R_WIDTH-1:0]         R,
  output logic                       upd_valid,
  output logic [AW-1:0]              upd_addr,
  output logic [Q_WIDTH-1:0]         Q_new
);

  logic [2:0]                       state_q, state_d;
  logic [N_LEVEL-1:0][Q_WIDTH-1:0]  row_q, row_d;
  logic [DW-1:0]                    idx_q, idx_d, arg_q, arg_d;
  logic [Q_WIDTH-1:0]               max_q, max_d, qact_q, qact_d, prev_qact_q, prev_qact_d;
  logic [7:0]                       lfsr_q, lfsr_d;
  logic [AW-1:0]                    a_q, a_d, prev_a_q, prev_a_d;
  logic                             have_prev_q, have_prev_d;
  logic [R_WIDTH-1:0]               r_q, r_d;
  logic [RW-1:0]                    road_q, road_d, next_road, cand;
  logic [Q_WIDTH-1:0]               cur;
  logic [DW-1:0]                    dur;
  logic                             found, explore;

  // First enabled road after the current one; holds if none qualifies.
  // N_ROAD is a power of two, so the RW-bit add wraps naturally.
  always_comb begin
    next_road = road_q;
    found     = 1'b0;
    cand      = road_q;
    for (int i = 1; i < N_ROAD; i++) begin
      cand = road_q + RW'(i);
      if (!found && road_en[cand]) begin
        next_road = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    max_d       = max_q;
    qact_d      = qact_q;
    prev_qact_d = prev_qact_q;
    a_d         = a_q;
    prev_a_d    = prev_a_q;
    have_prev_d = have_prev_q;
    r_d         = r_q;
    road_d      = road_q;
    lfsr_d      = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    cur         = row_q[idx_q];
    explore     = !mode && (lfsr_q < epsilon);
    dur         = explore ? lfsr_q[DW-1:0] : arg_q;

    case (state_q)
      S_IDLE: if (q_valid) begin
        row_d   = q_row;
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        // Strict greater-than keeps the lowest index on ties.
        if (idx_q == '0 || $signed(cur) > $signed(max_q)) begin
          max_d = cur;
          arg_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == DW'(N_LEVEL - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        a_d     = {dur, road_q};
        qact_d  = row_q[dur];
        state_d = S_ACT;
      end
      S_ACT: if (act_ready) begin
        prev_a_d    = a_q;
        prev_qact_d = qact_q;
        have_prev_d = 1'b1;
        road_d      = next_road;
        state_d     = S_WAIT_R;
      end
      S_WAIT_R: if (r_valid) begin
        r_d     = R;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      max_q       <= '0;
      qact_q      <= '0;
      prev_qact_q <= '0;
      a_q         <= '0;
      prev_a_q    <= '0;
      have_prev_q <= 1'b0;
      r_q         <= '0;
      road_q      <= '0;
      lfsr_q      <= SEED;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      max_q       <= max_d;
      qact_q      <= qact_d;
      prev_qact_q <= prev_qact_d;
      a_q         <= a_d;
      prev_a_q    <= prev_a_d;
      have_prev_q <= have_prev_d;
      r_q         <= r_d;
      road_q      <= road_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Update uses this row's max with the previous step's action and reward.
  agent_seq_q_update #(
    .Q_WIDTH (Q_WIDTH),
    .R_WIDTH (R_WIDTH),
    .AW      (AW)
  ) u_q_update (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == S_DECIDE && have_prev_q),
    .r_prev     (r_q),
    .q_max      (max_q),
    .q_act_prev (prev_qact_q),
    .alpha      (alpha),
    .gamma      (gamma),
    .addr_in    (prev_a_q),
    .upd_valid  (upd_valid),
    .upd_addr   (upd_addr),
    .q_new      (Q_new)
  );

  assign road_sel  = road_q;
  assign q_ready   = (state_q == S_IDLE);
  assign act_valid = (state_q == S_ACT);
  assign A         = a_q;

endmodule

// File: tb/tb_agent_seq.sv
// tb_agent_seq: randomized self-checking bench for agent_seq against a
// step-level reference model (argmax, exploration, road rotation, Bellman
// update with saturation) plus directed tie/update/saturation/mask/reset cases.
module tb_agent_seq;

  localparam int         N_ROAD  = 4;
  localparam int         L_WIDTH = 4;
  localparam int         Q_WIDTH = 16;
  localparam int         R_WIDTH = 16;
  localparam int         NL      = 4;
  localparam int         RW      = 2;
  localparam int         DW      = 2;
  localparam logic [7:0] SEED    = 8'hA5;

  logic                   clk = 1'b0;
  logic                   rst, mode;
  logic [7:0]             epsilon;
  logic [2:0]             alpha, gamma;
  logic [N_ROAD-1:0]      road_en;
  logic [RW-1:0]          road_sel;
  logic                   q_valid, q_ready;
  logic [Q_WIDTH*NL-1:0]  q_row;
  logic                   act_valid, act_ready;
  logic [RW+DW-1:0]       A;
  logic                   r_valid;
  logic [R_WIDTH-1:0]     R;
  logic                   upd_valid;
  logic [RW+DW-1:0]       upd_addr;
  logic [Q_WIDTH-1:0]     Q_new;

  agent_seq #(
    .N_ROAD (N_ROAD), .L_WIDTH (L_WIDTH), .Q_WIDTH (Q_WIDTH),
    .R_WIDTH (R_WIDTH), .SEED (SEED)
  ) dut (
    .clk (clk), .rst (rst), .mode (mode), .epsilon (epsilon),
    .alpha (alpha), .gamma (gamma), .road_en (road_en), .road_sel (road_sel),
    .q_valid (q_valid), .q_ready (q_ready), .q_row (q_row),
    .act_valid (act_valid), .act_ready (act_ready), .A (A),
    .r_valid (r_valid), .R (R),
    .upd_valid (upd_valid), .upd_addr (upd_addr), .Q_new (Q_new)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  logic [7:0] m_lfsr, m_lfsr_prev;
  int m_road, m_have_prev, m_prev_a, m_prev_qact, m_r;
  int row_v[NL];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    int x;
    x = int'(v) / 2;
    if (v[0]) x = x ^ 184;  // feedback for taps 8,6,5,4
    return 8'(x);
  endfunction

  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst ? SEED : lfsr_next(m_lfsr);
  end

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int road_after(input int cur, input logic [N_ROAD-1:0] en);
    for (int i = 1; i < N_ROAD; i++)
      if (en[(cur + i) % N_ROAD]) return (cur + i) % N_ROAD;
    return cur;
  endfunction

  function automatic int rnd_q();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_reset(input string t);
    chk({t, "_road_sel"}, road_sel, 0);
    chk({t, "_q_ready"}, q_ready, 1);
    chk({t, "_act_valid"}, act_valid, 0);
    chk({t, "_upd_valid"}, upd_valid, 0);
    chk({t, "_A"}, A, 0);
    chk({t, "_upd_addr"}, upd_addr, 0);
    chk({t, "_Q_new"}, $signed(Q_new), 0);
  endtask

  // One full decision step: row handshake, latency, action/update check,
  // back-pressure for 'hold' cycles, action handshake, reward.
  task automatic do_step(input int hold, input int rwd);
    int cnt, qmax, arg, dur, ea, qact, td, qn;
    logic [7:0] lf;
    bit to;
    @(negedge clk);
    chk("q_ready_idle", q_ready, 1);
    for (int i = 0; i < NL; i++) q_row[i*Q_WIDTH +: Q_WIDTH] = 16'(row_v[i]);
    q_valid = 1'b1;
    @(posedge clk);
    cnt = 0; to = 1'b0;
    forever begin
      @(negedge clk);
      q_valid = 1'b0;
      if (act_valid) break;
      cnt++;
      if (cnt > 40) begin to = 1'b1; break; end
    end
    chk("act_latency", cnt, NL + 1);
    if (to) return;

    qmax = row_v[0]; arg = 0;
    for (int i = 1; i < NL; i++)
      if (row_v[i] > qmax) begin qmax = row_v[i]; arg = i; end
    lf   = m_lfsr_prev;  // LFSR value during the decision cycle
    dur  = (mode == 1'b0 && lf < epsilon) ? int'(lf) % NL : arg;
    ea   = dur * N_ROAD + m_road;
    qact = row_v[dur];
    chk("A", A, ea);
    chk("upd_valid", upd_valid, m_have_prev);
    if (m_have_prev != 0) begin
      td = m_r + (qmax >>> gamma) - m_prev_qact;
      qn = sat16(m_prev_qact + (td >>> alpha));
      chk("upd_addr", upd_addr, m_prev_a);
      chk("Q_new", $signed(Q_new), qn);
    end

    for (int i = 0; i < hold; i++) begin
      act_ready = 1'b0;
      @(negedge clk);
      chk("A_stable", A, ea);
      chk("act_hold", act_valid, 1);
      chk("q_ready_bp", q_ready, 0);
      if (i == 0) chk("upd_pulse", upd_valid, 0);
    end
    act_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    act_ready = 1'b0;
    m_prev_a = ea; m_prev_qact = qact; m_have_prev = 1;
    m_road = road_after(m_road, road_en);
    chk("road_sel", road_sel, m_road);
    chk("act_drop", act_valid, 0);
    chk("upd_drop", upd_valid, 0);

    R = 16'(rwd); r_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_valid = 1'b0;
    m_r = rwd;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; epsilon = 8'd0; alpha = 3'd1; gamma = 3'd1;
    road_en = 4'hF; q_valid = 1'b0; q_row = '0; act_ready = 1'b0;
    r_valid = 1'b0; R = '0;
    m_road = 0; m_have_prev = 0; m_prev_a = 0; m_prev_qact = 0; m_r = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst");

    // greedy with tie, first step: no update, back-pressure 10 cycles
    row_v = '{40, -5, 100, 100};
    do_step(10, 40);
    chk("tie_dur", int'(A[RW+DW-1:RW]), 2);

    // update: prev Q_act=20, R=40, next max=100, alpha=gamma=1 -> 55
    row_v = '{20, 0, 0, 0};    do_step(0, 40);
    row_v = '{100, 0, 0, 0};   do_step(1, 32767);
    chk("q_new_55", $signed(Q_new), 55);

    // saturation, both directions
    alpha = 3'd0; gamma = 3'd0;
    row_v = '{32000, 0, 0, 0};             do_step(0, 32767);
    row_v = '{32767, 0, 0, 0};             do_step(0, -32768);
    chk("sat_pos", $signed(Q_new), 32767);
    row_v = '{-32000, -32768, -32768, -32768}; do_step(0, -32768);
    row_v = '{-32768, -32768, -32768, -32768}; do_step(0, 0);
    chk("sat_neg", $signed(Q_new), -32768);

    // road mask: move to road 1, then 1010 gives 3,1,3
    road_en = 4'b0010; row_v = '{1, 2, 3, 4}; do_step(0, 5);
    chk("mask_start", road_sel, 1);
    road_en = 4'b1010;
    do_step(0, 1); chk("mask_seq0", road_sel, 3);
    do_step(0, 2); chk("mask_seq1", road_sel, 1);
    do_step(0, 3); chk("mask_seq2", road_sel, 3);
    road_en = 4'b1000; do_step(0, 4); chk("mask_only_cur", road_sel, 3);
    road_en = 4'b0000; do_step(0, 4); chk("mask_zero", road_sel, 3);
    road_en = 4'hF;

    // exploration disabled by epsilon=0
    mode = 1'b0; epsilon = 8'd0; alpha = 3'd2; gamma = 3'd1;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NL; i++) row_v[i] = rnd_q();
      do_step(0, rnd_q());
    end

    // epsilon=255: duration follows the LFSR
    epsilon = 8'd255;
    for (int s = 0; s < 256; s++) begin
      for (int i = 0; i < NL; i++) row_v[i] = rnd_q();
      do_step(0, rnd_q());
    end

    // fully randomized steps
    for (int s = 0; s < 60; s++) begin
      mode    = 1'($urandom_range(0, 1));
      epsilon = 8'($urandom_range(0, 255));
      alpha   = 3'($urandom_range(0, 7));
      gamma   = 3'($urandom_range(0, 7));
      road_en = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) row_v[i] = rnd_q();
      do_step(int'($urandom_range(0, 3)), rnd_q());
    end

    // reset during SCAN abandons the step and clears have_prev
    @(negedge clk);
    q_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0;
    m_have_prev = 0; m_road = 0;
    mode = 1'b1; road_en = 4'hF;
    row_v = '{7, 9, 9, 1};
    do_step(2, 10);
    chk("post_rst_dur", int'(A[RW+DW-1:RW]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
